jk_updown_counter: RTL and testbench



---
 rtl/jk_updown_counter.sv | 84 ++++++++
 tb/tb_jk_updown_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jk_updown_counter.sv
// Presettable modulo-MODULUS up/down counter built from per-bit JK toggle stages, with cascade carry/borrow.
// Latency: Q and TC_PULSE update one clk edge after sampling; MAXMIN/RCO_N are combinational from Q, UP, EN.
// Backpressure: none; EN gates counting each edge, and downstream stages are enabled from ~RCO_N.
module jk_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             CLR_N,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QBAR,
    output logic             MAXMIN,
    output logic             RCO_N,
    output logic             TC_PULSE
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    // Master-slave JK stage next state: J sets, K resets, J=K=1 toggles.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_jk;
    logic [WIDTH-1:0] q_next;
    logic             ones_below;
    logic             zeros_below;
    logic             at_max;
    logic             at_zero;
    logic             over_range;
    logic             wrap;

    always_comb begin
        t           = '0;
        q_jk        = '0;
        ones_below  = 1'b1;
        zeros_below = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]        = EN & (UP ? ones_below : zeros_below);
            q_jk[i]     = jk_next(Q[i], t[i], t[i]);
            ones_below  = ones_below & Q[i];
            zeros_below = zeros_below & ~Q[i];
        end
    end

    assign at_max     = (Q == MAX_Q);
    assign at_zero    = (Q == '0);
    assign over_range = ({1'b0, Q} >= MOD_EXT);
    assign wrap       = UP ? (at_max | over_range) : at_zero;

    // The modulus wrap overrides the binary toggle pattern; with a full-range modulus both agree.
    always_comb begin
        q_next = q_jk;
        if (wrap) begin
            q_next = UP ? '0 : MAX_Q;
        end
    end

    always_ff @(posedge clk or negedge CLR_N) begin
        if (!CLR_N) begin
            Q        <= '0;
            TC_PULSE <= 1'b0;
        end else if (LOAD) begin
            Q        <= D;
            TC_PULSE <= 1'b0;
        end else if (EN) begin
            Q        <= q_next;
            TC_PULSE <= wrap;
        end else begin
            TC_PULSE <= 1'b0;
        end
    end

    assign QBAR   = ~Q;
    assign MAXMIN = (UP & at_max) | (~UP & at_zero);
    assign RCO_N  = ~(EN & MAXMIN);

endmodule

// File: tb/tb_jk_updown_counter.sv
// Bench for jk_updown_counter: MODULUS=10 instance driven by directed steps, plus a two-stage cascade.
module tb_jk_updown_counter;

    typedef struct {
        int         tag;
        int         kind;
        int         id;
        logic [3:0] q;
        logic [3:0] qb;
        logic       mm;
        logic       rco;
        logic       tc;
        logic [7:0] cval;
    } exp_t;

    exp_t sb_q[$];

    logic       clk;
    logic       clr_n, en, up, load;
    logic [3:0] d, q, qbar;
    logic       maxmin, rco_n, tc_pulse;

    logic       casc_clr_n, casc_en;
    logic [3:0] cl_q, cl_qbar, ch_q, ch_qbar;
    logic       cl_mm, cl_rco_n, cl_tc, ch_mm, ch_rco_n, ch_tc;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int stp   = 0;

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .CLR_N(clr_n), .EN(en), .UP(up), .LOAD(load), .D(d),
        .Q(q), .QBAR(qbar), .MAXMIN(maxmin), .RCO_N(rco_n), .TC_PULSE(tc_pulse)
    );

    jk_updown_counter #(.WIDTH(4), .MODULUS(16)) casc_lo (
        .clk(clk), .CLR_N(casc_clr_n), .EN(casc_en), .UP(1'b1), .LOAD(1'b0), .D(4'h0),
        .Q(cl_q), .QBAR(cl_qbar), .MAXMIN(cl_mm), .RCO_N(cl_rco_n), .TC_PULSE(cl_tc)
    );

    jk_updown_counter #(.WIDTH(4), .MODULUS(16)) casc_hi (
        .clk(clk), .CLR_N(casc_clr_n), .EN(~cl_rco_n), .UP(1'b1), .LOAD(1'b0), .D(4'h0),
        .Q(ch_q), .QBAR(ch_qbar), .MAXMIN(ch_mm), .RCO_N(ch_rco_n), .TC_PULSE(ch_tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, id, got, exp);
        end
    endtask

    // Drive one edge's inputs at the falling edge and queue the hand-computed result for that edge.
    task automatic step(input logic c, input logic ld, input logic e_n, input logic u,
                        input logic [3:0] dv, input logic [3:0] eq, input logic etc);
        exp_t e;
        @(negedge clk);
        clr_n = c; load = ld; en = e_n; up = u; d = dv;
        stp++;
        e.tag  = cyc + 1;
        e.kind = 0;
        e.id   = stp;
        e.q    = eq;
        e.qb   = ~eq;
        e.mm   = u ? (eq == 4'd9) : (eq == 4'd0);
        e.rco  = ~(e_n & e.mm);
        e.tc   = etc;
        e.cval = 8'h00;
        sb_q.push_back(e);
    endtask

    // Monitor: shortly after each rising edge, retire every expectation due at this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
                e = sb_q.pop_front();
                if (e.tag != cyc) begin
                    chk("sb_late", e.id, cyc, e.tag);
                end else if (e.kind == 0) begin
                    chk("q", e.id, q, e.q);
                    chk("qbar", e.id, qbar, e.qb);
                    chk("maxmin", e.id, maxmin, e.mm);
                    chk("rco_n", e.id, rco_n, e.rco);
                    chk("tc_pulse", e.id, tc_pulse, e.tc);
                end else begin
                    chk("cascade", e.id, {ch_q, cl_q}, e.cval);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ce;
        clr_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = 4'h0;
        casc_clr_n = 1'b0; casc_en = 1'b0;
        #1;
        chk("rst_q", 0, q, 4'h0);
        chk("rst_qbar", 0, qbar, 4'hF);
        chk("rst_tc", 0, tc_pulse, 1'b0);
        chk("rst_maxmin", 0, maxmin, 1'b1);
        chk("rst_rco_n", 0, rco_n, 1'b1);
        en = 1'b1;
        #1;
        chk("rst_rco_n_en", 0, rco_n, 1'b0);
        en = 1'b0;
        repeat (2) @(posedge clk);

        // Up count through the wrap; first edge after release is a normal count.
        step(1,0,1,1,0, 4'd1,0); step(1,0,1,1,0, 4'd2,0); step(1,0,1,1,0, 4'd3,0);
        step(1,0,1,1,0, 4'd4,0); step(1,0,1,1,0, 4'd5,0); step(1,0,1,1,0, 4'd6,0);
        step(1,0,1,1,0, 4'd7,0); step(1,0,1,1,0, 4'd8,0); step(1,0,1,1,0, 4'd9,0);
        step(1,0,1,1,0, 4'd0,1); step(1,0,1,1,0, 4'd1,0); step(1,0,1,1,0, 4'd2,0);

        // Down through zero.
        step(1,1,0,0,4'd2, 4'd2,0);
        step(1,0,1,0,0, 4'd1,0); step(1,0,1,0,0, 4'd0,0);
        step(1,0,1,0,0, 4'd9,1); step(1,0,1,0,0, 4'd8,0);

        // Load beats enable; out-of-range recovery in both directions.
        step(1,1,1,1,4'hC, 4'd12,0); step(1,0,1,1,0, 4'd0,1);
        step(1,1,1,1,4'hC, 4'd12,0); step(1,0,1,0,0, 4'd11,0);

        // Hold, then reverse direction every edge.
        step(1,1,0,1,4'd5, 4'd5,0);
        step(1,0,0,1,0, 4'd5,0); step(1,0,0,1,0, 4'd5,0); step(1,0,0,1,0, 4'd5,0);
        step(1,0,1,1,0, 4'd6,0); step(1,0,1,0,0, 4'd5,0); step(1,0,1,1,0, 4'd6,0);

        // MAXMIN/RCO_N follow UP and EN combinationally while Q sits at 9.
        step(1,1,0,1,4'd9, 4'd9,0);
        @(negedge clk);
        up = 1'b0; #1;
        chk("mm_up0", stp, maxmin, 1'b0);
        chk("rco_up0", stp, rco_n, 1'b1);
        up = 1'b1; en = 1'b1; #1;
        chk("mm_up1", stp, maxmin, 1'b1);
        chk("rco_up1_en", stp, rco_n, 1'b0);
        en = 1'b0; #1;

        // Back-to-back wraps at the boundary keep TC_PULSE high.
        step(1,0,1,1,0, 4'd0,1); step(1,0,1,0,0, 4'd9,1); step(1,0,1,0,0, 4'd8,0);

        // Asynchronous clear discards a pending wrap strobe.
        step(1,1,0,0,4'd0, 4'd0,0); step(1,0,1,0,0, 4'd9,1);
        @(negedge clk);
        clr_n = 1'b0; en = 1'b1; up = 1'b1; #1;
        chk("aclr_q", stp, q, 4'h0);
        chk("aclr_qbar", stp, qbar, 4'hF);
        chk("aclr_tc", stp, tc_pulse, 1'b0);
        step(0,0,1,1,0, 4'd0,0);
        step(1,0,1,1,0, 4'd1,0);
        step(1,0,0,1,0, 4'd1,0);

        // Cascade: 300 up edges, each one checked against the running count.
        @(negedge clk);
        casc_clr_n = 1'b1; casc_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            casc_en = 1'b1;
            ce.tag  = cyc + 1;
            ce.kind = 1;
            ce.id   = i + 1;
            ce.q    = 4'h0; ce.qb = 4'h0; ce.mm = 1'b0; ce.rco = 1'b0; ce.tc = 1'b0;
            ce.cval = 8'((i + 1) % 256);
            sb_q.push_back(ce);
        end
        @(negedge clk);
        casc_en = 1'b0;
        chk("cascade_final", 300, {ch_q, cl_q}, 8'd44);

        repeat (2) @(posedge clk);
        #3;
        chk("sb_drain", 0, sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
